spi_tx_fifo_sequencer: RTL and testbench

- Drains bytes from the TX FIFO (wr_cs/wr_en, rd_cs/rd_en, full/empty flags) into the SPI master shift register, one burst per host command.
- Owns the FIFO read port and the slave-select line.
- Enforces slave-select setup/hold timing and aborts a burst if the FIFO starves.
- Sits between the host register interface and the SPI shifter in the SPI peripheral.

---
 rtl/spi_tx_fifo_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_spi_tx_fifo_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_fifo_sequencer.sv
// Burst sequencer between the TX FIFO read port and the SPI shifter.
// Owns slave select, enforces its setup/hold timing and aborts a burst when the FIFO starves.
`timescale 1ns/1ps

module spi_tx_fifo_sequencer #(
    parameter int WIDTH       = 8,
    parameter int LEN_W       = 8,
    parameter int CS_SETUP    = 2,
    parameter int CS_HOLD     = 2,
    parameter int STALL_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [LEN_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] sent_cnt,
    output logic             fifo_rd_cs,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_out,
    input  logic             fifo_empty,
    output logic             sh_start,
    output logic [WIDTH-1:0] sh_data,
    input  logic             sh_done,
    output logic             ss_n
);

    localparam int TMR_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT_DATA,
        S_FETCH,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t             state, state_n;
    logic [LEN_W-1:0]   remaining, remaining_n;
    logic [TMR_W-1:0]   timer, timer_n;
    logic [STALL_W-1:0] stall_cnt, stall_n;
    logic               go_prev;
    logic               go_rise;
    logic               stalled_out;
    logic               pop;

    logic               busy_n, done_n, error_n, sh_start_n, ss_n_n;
    logic [LEN_W-1:0]   sent_n;
    logic [WIDTH-1:0]   sh_data_n;

    // A go level held across a whole burst must not retrigger once we are back in IDLE,
    // so a burst is launched on the rising edge of go only.
    assign go_rise     = go && !go_prev;
    assign stalled_out = (stall_cnt == STALL_W'(STALL_LIMIT));
    assign pop         = (state == S_WAIT_DATA) && !fifo_empty && !stalled_out;
    assign fifo_rd_cs  = pop;
    assign fifo_rd_en  = pop;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        timer_n     = timer;
        stall_n     = stall_cnt;
        done_n      = 1'b0;
        sh_start_n  = 1'b0;
        error_n     = error;
        sent_n      = sent_cnt;
        sh_data_n   = sh_data;
        ss_n_n      = ss_n;

        case (state)
            S_IDLE: begin
                if (go_rise) begin
                    error_n = 1'b0;
                    sent_n  = '0;
                    if (burst_len != '0) begin
                        remaining_n = burst_len;
                        timer_n     = '0;
                        ss_n_n      = 1'b0;
                        state_n     = S_SETUP;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end

            S_SETUP: begin
                if (timer == TMR_W'(CS_SETUP - 1)) begin
                    timer_n = '0;
                    stall_n = '0;
                    state_n = S_WAIT_DATA;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end

            S_WAIT_DATA: begin
                if (pop) begin
                    stall_n = '0;
                    state_n = S_FETCH;
                end else if (stall_cnt == STALL_W'(STALL_LIMIT - 1)) begin
                    // Starved for STALL_LIMIT consecutive cycles: give up, but still honour hold.
                    error_n = 1'b1;
                    stall_n = '0;
                    timer_n = '0;
                    state_n = S_HOLD;
                end else begin
                    stall_n = stall_cnt + STALL_W'(1);
                end
            end

            // The popped word appears on fifo_out one cycle after the pop edge.
            S_FETCH: begin
                sh_data_n  = fifo_out;
                sh_start_n = 1'b1;
                sent_n     = sent_cnt + LEN_W'(1);
                state_n    = S_SHIFT;
            end

            S_SHIFT: begin
                if (sh_done) begin
                    remaining_n = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        timer_n = '0;
                        state_n = S_HOLD;
                    end else begin
                        stall_n = '0;
                        state_n = S_WAIT_DATA;
                    end
                end
            end

            S_HOLD: begin
                if (timer == TMR_W'(CS_HOLD - 1)) begin
                    timer_n = '0;
                    ss_n_n  = 1'b1;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end

            default: begin
                ss_n_n  = 1'b1;
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            timer     <= '0;
            stall_cnt <= '0;
            go_prev   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            sent_cnt  <= '0;
            sh_start  <= 1'b0;
            sh_data   <= '0;
            ss_n      <= 1'b1;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            timer     <= timer_n;
            stall_cnt <= stall_n;
            go_prev   <= go;
            busy      <= busy_n;
            done      <= done_n;
            error     <= error_n;
            sent_cnt  <= sent_n;
            sh_start  <= sh_start_n;
            sh_data   <= sh_data_n;
            ss_n      <= ss_n_n;
        end
    end

endmodule

// File: tb/tb_spi_tx_fifo_sequencer.sv
// Self-checking bench: behavioural FIFO and shifter around the sequencer, with
// expectations derived from FIFO order, burst lengths and the ss_n timing rules.
`timescale 1ns/1ps

module tb_spi_tx_fifo_sequencer;

    localparam int WIDTH       = 8;
    localparam int LEN_W       = 8;
    localparam int CS_SETUP    = 2;
    localparam int CS_HOLD     = 2;
    localparam int STALL_LIMIT = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             go = 1'b0;
    logic [LEN_W-1:0] burst_len = '0;
    logic             busy, done, error;
    logic [LEN_W-1:0] sent_cnt;
    logic             fifo_rd_cs, fifo_rd_en;
    logic [WIDTH-1:0] fifo_out = '0;
    logic             fifo_empty;
    logic             sh_start;
    logic [WIDTH-1:0] sh_data;
    logic             sh_done;
    logic             ss_n;

    always #5 clk = ~clk;

    spi_tx_fifo_sequencer #(
        .WIDTH(WIDTH), .LEN_W(LEN_W), .CS_SETUP(CS_SETUP),
        .CS_HOLD(CS_HOLD), .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .burst_len(burst_len),
        .busy(busy), .done(done), .error(error), .sent_cnt(sent_cnt),
        .fifo_rd_cs(fifo_rd_cs), .fifo_rd_en(fifo_rd_en), .fifo_out(fifo_out),
        .fifo_empty(fifo_empty), .sh_start(sh_start), .sh_data(sh_data),
        .sh_done(sh_done), .ss_n(ss_n)
    );

    // Behavioural FIFO: mem doubles as the log of every word ever pushed.
    logic [WIDTH-1:0] mem [0:1023];
    int wp = 0;
    int rp = 0;
    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (fifo_rd_en && (wp != rp)) begin
            fifo_out <= mem[rp];
            rp       <= rp + 1;
        end
    end

    // Behavioural shifter with a random 1..4 cycle latency per word.
    int   sh_cnt = 0;
    logic model_done = 1'b0;
    logic stray_done = 1'b0;
    assign sh_done = model_done | stray_done;

    always @(posedge clk) begin
        if (rst) begin
            sh_cnt     <= 0;
            model_done <= 1'b0;
        end else begin
            model_done <= 1'b0;
            if (sh_cnt > 0) begin
                sh_cnt <= sh_cnt - 1;
                if (sh_cnt == 1) model_done <= 1'b1;
            end else if (sh_start) begin
                sh_cnt <= int'($urandom_range(4, 1));
            end
        end
    end

    // Event monitor, sampled on the falling edge.
    logic [WIDTH-1:0] got_w [0:1023];
    int   cyc = 0, m_got = 0, m_pop = 0, m_done = 0, m_shd = 0, m_fall = 0;
    int   m_low = 0, m_busy = 0, m_under = 0, m_csmis = 0, m_overlap = 0;
    int   fall_cyc = 0, first_rd_cyc = 0, rise_cyc = 0, last_shd_cyc = 0, err_rise_cyc = 0;
    logic rd_since_fall = 1'b1;
    logic ss_prev = 1'b1;
    logic err_prev = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sh_start) begin
            got_w[m_got] <= sh_data;
            m_got        <= m_got + 1;
        end
        if (fifo_rd_en) begin
            m_pop <= m_pop + 1;
            if (!rd_since_fall) begin
                first_rd_cyc  <= cyc;
                rd_since_fall <= 1'b1;
            end
        end
        if (fifo_rd_en && fifo_empty) m_under <= m_under + 1;
        if (fifo_rd_cs !== fifo_rd_en) m_csmis <= m_csmis + 1;
        if (done) begin
            m_done <= m_done + 1;
            if (busy) m_overlap <= m_overlap + 1;
        end
        if (sh_done) begin
            m_shd        <= m_shd + 1;
            last_shd_cyc <= cyc;
        end
        if (!ss_n) m_low <= m_low + 1;
        if (busy) m_busy <= m_busy + 1;
        if (ss_prev && !ss_n) begin
            m_fall        <= m_fall + 1;
            fall_cyc      <= cyc;
            rd_since_fall <= 1'b0;
        end
        if (!ss_prev && ss_n) rise_cyc <= cyc;
        if (!err_prev && error) err_rise_cyc <= cyc;
        ss_prev  <= ss_n;
        err_prev <= error;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        mem[wp] = w;
        wp      = wp + 1;
    endtask

    task automatic start(input int len);
        go        = 1'b1;
        burst_len = LEN_W'(len);
        tick();
        go        = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int d0 = m_done;
        int k  = 0;
        while (m_done == d0 && k < limit) begin
            tick();
            k++;
        end
        check({tag, "_done_seen"}, 32'(m_done != d0), 1);
    endtask

    // Checks n words sent since got index g0 against the next n words of FIFO order.
    int exp_rd = 0;
    task automatic check_words(input string tag, input int g0, input int n);
        for (int i = 0; i < n; i++)
            check($sformatf("%s_word%0d", tag, i), got_w[g0 + i], mem[exp_rd + i]);
        exp_rd = exp_rd + n;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, p0, d0, f0, s0, b0, l0, k, n, lvl, extra;

        // Reset state
        #1 rst = 1'b1;
        tick(3);
        check("rst_ss_n", ss_n, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_sent_cnt", sent_cnt, 0);
        check("rst_sh_start", sh_start, 0);
        check("rst_sh_data", sh_data, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        rst = 1'b0;
        tick(2);

        // Burst of three pre-loaded words
        g0 = m_got; p0 = m_pop; d0 = m_done;
        push(8'h11); push(8'h22); push(8'h33);
        start(3);
        wait_done("t1", 200);
        check("t1_setup_cycles", first_rd_cyc - fall_cyc, CS_SETUP);
        check("t1_hold_cycles", rise_cyc - last_shd_cyc, CS_HOLD + 1);
        check("t1_w0", got_w[g0], 8'h11);
        check("t1_w1", got_w[g0 + 1], 8'h22);
        check("t1_w2", got_w[g0 + 2], 8'h33);
        exp_rd = exp_rd + 3;
        check("t1_starts", m_got - g0, 3);
        check("t1_pops", m_pop - p0, 3);
        check("t1_done_pulses", m_done - d0, 1);
        check("t1_sent_cnt", sent_cnt, 3);
        check("t1_error", error, 0);
        check("t1_fifo_empty", fifo_empty, 1);
        check("t1_ss_n", ss_n, 1);

        // Starvation abort on an empty FIFO
        tick(2);
        p0 = m_pop; d0 = m_done;
        start(2);
        wait_done("t2", 100);
        check("t2_pops", m_pop - p0, 0);
        check("t2_error", error, 1);
        check("t2_sent_cnt", sent_cnt, 0);
        check("t2_ss_n", ss_n, 1);
        check("t2_done_pulses", m_done - d0, 1);
        check("t2_err_time", err_rise_cyc - fall_cyc, CS_SETUP + STALL_LIMIT);
        check("t2_ss_rise_time", rise_cyc - fall_cyc, CS_SETUP + STALL_LIMIT + CS_HOLD);
        tick(2);
        g0 = m_got;
        push(8'($urandom));
        start(1);
        check("t2_go_clears_error", error, 0);
        wait_done("t2b", 100);
        check_words("t2b", g0, 1);
        check("t2b_sent_cnt", sent_cnt, 1);

        // Late second word arrives within the stall window
        tick(2);
        g0 = m_got; s0 = m_shd;
        push(8'h55);
        start(2);
        k = 0;
        while (m_shd == s0 && k < 50) begin tick(); k++; end
        check("t3_first_shd_seen", 32'(m_shd != s0), 1);
        tick(10);
        push(8'h66);
        wait_done("t3", 100);
        check("t3_w0", got_w[g0], 8'h55);
        check("t3_w1", got_w[g0 + 1], 8'h66);
        exp_rd = exp_rd + 2;
        check("t3_error", error, 0);
        check("t3_sent_cnt", sent_cnt, 2);

        // Zero-length burst
        tick(2);
        d0 = m_done; b0 = m_busy; l0 = m_low;
        start(0);
        wait_done("t4", 20);
        tick(3);
        check("t4_done_pulses", m_done - d0, 1);
        check("t4_ss_low_cycles", m_low - l0, 0);
        check("t4_busy_cycles", m_busy - b0, 0);

        // Asynchronous reset mid-burst
        tick(2);
        g0 = m_got;
        for (int i = 0; i < 4; i++) push(8'($urandom));
        start(4);
        k = 0;
        while (m_got == g0 && k < 50) begin tick(); k++; end
        check("t5_first_start_seen", 32'(m_got != g0), 1);
        #2 rst = 1'b1;
        #1;
        check("t5_ss_n_async", ss_n, 1);
        check("t5_busy_async", busy, 0);
        check("t5_sh_start_async", sh_start, 0);
        check("t5_sent_cnt_async", sent_cnt, 0);
        tick(2);
        rst = 1'b0;
        check_words("t5a", g0, 1);
        check("t5_fifo_untouched", wp - rp, 3);
        tick(2);
        g0 = m_got;
        start(3);
        wait_done("t5", 200);
        check_words("t5b", g0, 3);
        check("t5_sent_cnt", sent_cnt, 3);
        check("t5_error", error, 0);

        // go held high for the whole burst, stray sh_done while waiting for data
        tick(2);
        g0 = m_got; p0 = m_pop; d0 = m_done; f0 = m_fall; s0 = m_shd;
        push(8'($urandom));
        go = 1'b1; burst_len = LEN_W'(3);
        tick();
        k = 0;
        while (m_shd == s0 && k < 50) begin tick(); k++; end
        check("t6_first_shd_seen", 32'(m_shd != s0), 1);
        tick(2);
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        tick(2);
        push(8'($urandom)); push(8'($urandom));
        wait_done("t6", 200);
        tick(20);
        check("t6_bursts", m_fall - f0, 1);
        check("t6_done_pulses", m_done - d0, 1);
        check("t6_pops", m_pop - p0, 3);
        check("t6_sent_cnt", sent_cnt, 3);
        check("t6_busy_idle", busy, 0);
        check_words("t6", g0, 3);
        go = 1'b0;

        // Randomized bursts, leftover words carry over between bursts
        for (int it = 0; it < 8; it++) begin
            tick(int'($urandom_range(3, 1)));
            n     = int'($urandom_range(6, 1));
            lvl   = wp - exp_rd;
            extra = int'($urandom_range(2, 0));
            for (int i = 0; i < ((n > lvl) ? n - lvl : 0) + extra; i++) push(8'($urandom));
            g0 = m_got; p0 = m_pop;
            start(n);
            wait_done($sformatf("r%0d", it), 400);
            check($sformatf("r%0d_sent_cnt", it), sent_cnt, n);
            check($sformatf("r%0d_error", it), error, 0);
            check($sformatf("r%0d_pops", it), m_pop - p0, n);
            check($sformatf("r%0d_setup", it), first_rd_cyc - fall_cyc, CS_SETUP);
            check($sformatf("r%0d_hold", it), rise_cyc - last_shd_cyc, CS_HOLD + 1);
            check_words($sformatf("r%0d", it), g0, n);
            check($sformatf("r%0d_fifo_level", it), wp - rp, wp - exp_rd);
        end

        check("never_underflow", m_under, 0);
        check("rd_cs_equals_rd_en", m_csmis, 0);
        check("done_while_busy", m_overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
